seg_scan_driver: RTL

Parametrised multiplexed seven-segment display driver for an N-digit common-anode display. It owns its own refresh prescaler and digit scan counter, and decodes full hex (0-F). It supports per-digit decimal point and blanking, and double-buffers display data so updates land only on frame boundaries (no tearing). It sits between game/score logic and the board display pins.

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for seven-segment display logic: the hex glyph table,
// segment bit positions, the all-off pattern and the display buffer layout.
package seg_pkg;

    // Widest display the buffer layout can hold.
    localparam int MAX_DIGITS = 8;

    // Bit positions within the 8-bit segment word {DP,G,F,E,D,C,B,A}.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All segments dark, active-high sense (polarity is applied at the pins).
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Hex glyphs as active-high {G..A}; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // One full set of display contents, sized for the widest display.
    typedef struct packed {
        logic [4*MAX_DIGITS-1:0] digits;
        logic [MAX_DIGITS-1:0]   dp;
        logic [MAX_DIGITS-1:0]   blank;
    } disp_buf_t;

    // Power-up contents: every digit blanked.
    localparam disp_buf_t DISP_BUF_RESET = '{digits: '0, dp: '0, blank: '1};

endpackage

// File: rtl/seg_hex_decode.sv
// Pure combinational nibble to seven-segment glyph decoder (active-high {G..A}).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with double-buffered contents.
// Optional macro SEG_GHOST_BLANK_EN: darkens the display for the first
// DEAD_CYCLES counts of every digit slot to suppress ghosting.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int DEAD_CYCLES      = 8
) (
    input  logic                                                    src_clk,
    input  logic                                                    src_rst,
    input  logic [4*NUM_DIGITS-1:0]                                 digits,
    input  logic [NUM_DIGITS-1:0]                                   dp,
    input  logic [NUM_DIGITS-1:0]                                   blank,
    input  logic                                                    load,
    output logic [NUM_DIGITS-1:0]                                   anode,
    output logic [7:0]                                              segment,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0]  scan_idx,
    output logic                                                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [NUM_DIGITS-1:0] ANODE_IDLE = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            SEG_DARK   = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    disp_buf_t             shadow_reg, shadow_next;
    disp_buf_t             active_reg, active_next;
    logic                  pending_reg, pending_next;
    logic                  frame_done_reg;
    logic [NUM_DIGITS-1:0] anode_reg, anode_next;
    logic [7:0]            segment_reg, segment_next;
    logic [IDX_W-1:0]      scan_idx_reg;

    logic                  tick;
    logic                  boundary;

    // Widen the port data into the fixed-size buffer layout; absent digits stay blank.
    logic [4*MAX_DIGITS-1:0] in_digits;
    logic [MAX_DIGITS-1:0]   in_dp;
    logic [MAX_DIGITS-1:0]   in_blank;
    disp_buf_t               in_buf;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIGITS; gi++) begin : g_in
            if (gi < NUM_DIGITS) begin : g_used
                assign in_digits[4*gi +: 4] = digits[4*gi +: 4];
                assign in_dp[gi]            = dp[gi];
                assign in_blank[gi]         = blank[gi];
            end else begin : g_absent
                assign in_digits[4*gi +: 4] = 4'h0;
                assign in_dp[gi]            = 1'b0;
                assign in_blank[gi]         = 1'b1;
            end
        end
    endgenerate

    assign in_buf = '{digits: in_digits, dp: in_dp, blank: in_blank};

    // Prescaler, scan counter and double-buffer next-state logic.
    always_comb begin
        tick         = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
        boundary     = tick && (idx_reg == IDX_W'(NUM_DIGITS - 1));
        cnt_next     = tick ? '0 : cnt_reg + CNT_W'(1);
        idx_next     = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
        end
        shadow_next  = shadow_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        if (load && boundary) begin
            // Landing exactly on the frame edge: show it in the frame that starts now.
            active_next  = in_buf;
            pending_next = 1'b0;
        end else if (load) begin
            shadow_next  = in_buf;
            pending_next = 1'b1;
        end else if (boundary && pending_reg) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
        end
    end

    // Output decode works from next-state values so the registered pins line up
    // with the slot the counters are in, including the first slot of a new frame.
    logic [2:0] sel;
    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic       cur_blank;
    logic       dead;
    logic [6:0] cur_glyph;

    assign sel        = 3'(idx_next);
    assign cur_nibble = active_next.digits[{sel, 2'b00} +: 4];
    assign cur_dp     = active_next.dp[sel];
    assign cur_blank  = active_next.blank[sel];

`ifdef SEG_GHOST_BLANK_EN
    assign dead = (cnt_next < CNT_W'(DEAD_CYCLES));
`else
    assign dead = 1'b0;
`endif

    seg_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_glyph)
    );

    // Build active-high anode/segment words, then apply pin polarity last.
    logic [NUM_DIGITS-1:0] anode_raw;
    logic [7:0]            segment_raw;

    always_comb begin
        anode_raw   = '0;
        segment_raw = SEG_OFF;
        if (!cur_blank && !dead) begin
            anode_raw                = NUM_DIGITS'(1) << idx_next;
            segment_raw[SEG_G:SEG_A] = cur_glyph;
            segment_raw[SEG_DP]      = cur_dp;
        end
        anode_next   = (ANODE_ACTIVE_LOW != 0) ? ~anode_raw : anode_raw;
        segment_next = (SEG_ACTIVE_LOW != 0) ? ~segment_raw : segment_raw;
    end

    // State and registered outputs; reset forces every pin dark immediately.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shadow_reg     <= DISP_BUF_RESET;
            active_reg     <= DISP_BUF_RESET;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            anode_reg      <= ANODE_IDLE;
            segment_reg    <= SEG_DARK;
            scan_idx_reg   <= '0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            shadow_reg     <= shadow_next;
            active_reg     <= active_next;
            pending_reg    <= pending_next;
            frame_done_reg <= boundary;
            anode_reg      <= anode_next;
            segment_reg    <= segment_next;
            scan_idx_reg   <= idx_next;
        end
    end

    assign anode      = anode_reg;
    assign segment    = segment_reg;
    assign scan_idx   = scan_idx_reg;
    assign frame_done = frame_done_reg;

endmodule
